// File: rtl/mult_arb_pkg.sv
// Shared types and defaults for the multiplier arbiter: FSM state encoding and
// the default requester count and operand width.
package mult_arb_pkg;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/smul_core.sv
// Combinational signed multiply: both operands are sign-extended by one bit,
// multiplied signed, and the product is truncated to 2*W bits.
module smul_core #(
  parameter int W = 4
) (
  input  logic signed [W-1:0]   a,
  input  logic signed [W-1:0]   b,
  output logic signed [2*W-1:0] prod
);

  logic signed [W:0]     a_x;
  logic signed [W:0]     b_x;
  logic signed [2*W+1:0] full;

  // The 2*W-bit result holds every product, including (-2^(W-1))^2 = 2^(2W-2).
  function automatic logic signed [2*W-1:0] trunc_prod(input logic signed [2*W+1:0] x);
    return x[2*W-1:0];
  endfunction

  assign a_x  = {a[W-1], a};
  assign b_x  = {b[W-1], b};
  assign full = (2*W+2)'(a_x) * (2*W+2)'(b_x);
  assign prod = trunc_prod(full);

endmodule

// File: rtl/mult_arbiter.sv
// Arbitrates NREQ requesters onto one registered signed multiplier (IDLE/MUL/RESP).
// Define MULT_ARBITER_RR_EN for round-robin arbitration; default is fixed priority.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*W-1:0]        req_a,
  input  logic [NREQ*W-1:0]        req_b,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic signed [2*W-1:0]    rsp_prod,
  input  logic                     rsp_ready
);

  localparam int IDW = $clog2(NREQ);

  state_t                state;
  state_t                state_nxt;
  logic                  any_req;
  logic                  grant;
  logic [IDW-1:0]        win_id;
  logic signed [W-1:0]   a_p0;
  logic signed [W-1:0]   b_p0;
  logic [IDW-1:0]        id_p0;
  logic signed [2*W-1:0] prod_c;
  logic signed [2*W-1:0] prod_p1;

  assign any_req = |req_valid;
  assign grant   = (state == IDLE) && any_req && !rst;

`ifdef MULT_ARBITER_RR_EN
  logic [IDW-1:0] last_grant;

  always_comb begin
    int   idx;
    logic found;
    idx    = 0;
    found  = 1'b0;
    win_id = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (!found && req_valid[idx[IDW-1:0]]) begin
        found  = 1'b1;
        win_id = idx[IDW-1:0];
      end
    end
  end

  // Reset value NREQ-1 makes requester 0 the first in line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= IDW'(NREQ - 1);
    end else if (grant) begin
      last_grant <= win_id;
    end
  end
`else
  always_comb begin
    win_id = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        win_id = IDW'(i);
      end
    end
  end
`endif

  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[win_id] = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = MUL;
      MUL:     state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: operands of the granted requester
  always_ff @(posedge clk) begin
    if (grant) begin
      a_p0 <= req_a[int'(win_id)*W +: W];
      b_p0 <= req_b[int'(win_id)*W +: W];
    end
  end

  smul_core #(.W(W)) u_smul_core (
    .a    (a_p0),
    .b    (b_p0),
    .prod (prod_c)
  );

  // Stage p1: registered product, held through RESP until accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      id_p0   <= '0;
      prod_p1 <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        id_p0 <= win_id;
      end
      if (state == MUL) begin
        prod_p1 <= prod_c;
      end
    end
  end

  assign rsp_valid = (state == RESP);
  assign rsp_id    = id_p0;
  assign rsp_prod  = prod_p1;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with hand-computed expected values.
module tb_mult_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic        rsp_ready = 1'b1;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_prod;

  int n_assert = 0;
  int n_fail   = 0;
  int order[5];

  always #5 clk = ~clk;

  mult_arbiter #(.NREQ(4), .W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_prod  (rsp_prod),
    .rsp_ready (rsp_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef MULT_ARBITER_RR_EN
    order = '{0, 1, 2, 3, 0};
`else
    order = '{0, 0, 0, 0, 0};
`endif

    // Reset with all requests pending: nothing may be granted
    req_valid = 4'b1111;
    tick();
    tick();
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    chk("rst_prod",  32'(rsp_prod),  32'h0);
    chk("rst_id",    32'(rsp_id),    32'h0);
    rst = 1'b0;
    req_valid = 4'b0000;
    tick();

    // Single request: -7 * 2 = -14
    req_valid = 4'b0001;
    req_a = 16'h0009;
    req_b = 16'h0002;
    #1;
    chk("single_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0010;
    #1;
    chk("mul_ready_zero", 32'(req_ready), 32'h0);
    chk("mul_valid_zero", 32'(rsp_valid), 32'h0);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("single_valid", 32'(rsp_valid), 32'h1);
    chk("single_id",    32'(rsp_id),    32'h0);
    chk("single_prod",  32'(rsp_prod),  32'hF2);
    tick();
    #1;
    chk("dropped_valid", 32'(rsp_valid), 32'h0);
    chk("dropped_ready", 32'(req_ready), 32'h0);
    tick();
    #1;
    chk("dropped_stays_idle", 32'(rsp_valid), 32'h0);

    // Corner: -8 * -8 = 64
    req_valid = 4'b0100;
    req_a = 16'h0800;
    req_b = 16'h0800;
    #1;
    chk("c1_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0000;
    tick();
    #1;
    chk("c1_valid", 32'(rsp_valid), 32'h1);
    chk("c1_id",    32'(rsp_id),    32'h2);
    chk("c1_prod",  32'(rsp_prod),  32'h40);
    tick();

    // Corner: -1 * 2 = -2
    req_valid = 4'b0100;
    req_a = 16'h0F00;
    req_b = 16'h0200;
    #1;
    chk("c2_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0000;
    tick();
    #1;
    chk("c2_id",   32'(rsp_id),   32'h2);
    chk("c2_prod", 32'(rsp_prod), 32'hFE);
    tick();

    // Backpressure: 3 * -3 = -9, requester 1 keeps requesting
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    req_a = 16'h0030;
    req_b = 16'h00D0;
    #1;
    chk("bp_ready", 32'(req_ready), 32'h2);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_hold_valid", 32'(rsp_valid), 32'h1);
      chk("bp_hold_prod",  32'(rsp_prod),  32'hF7);
      chk("bp_hold_id",    32'(rsp_id),    32'h1);
      chk("bp_hold_ready", 32'(req_ready), 32'h0);
      tick();
    end
    rsp_ready = 1'b1;
    req_valid = 4'b0000;
    #1;
    chk("bp_handshake_valid", 32'(rsp_valid), 32'h1);
    tick();
    #1;
    chk("bp_after_valid", 32'(rsp_valid), 32'h0);
    chk("bp_after_ready", 32'(req_ready), 32'h0);

    // Reset during MUL discards the operation: 7 * 7 never appears
    req_valid = 4'b1000;
    req_a = 16'h7000;
    req_b = 16'h7000;
    #1;
    chk("rm_ready", 32'(req_ready), 32'h8);
    tick();
    req_valid = 4'b0000;
    rst = 1'b1;
    #1;
    chk("rm_async_valid", 32'(rsp_valid), 32'h0);
    chk("rm_async_prod",  32'(rsp_prod),  32'h0);
    chk("rm_async_id",    32'(rsp_id),    32'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rm_no_stale", 32'(rsp_valid), 32'h0);
    end

    // Contention: a_i = i+1, b_i = 3, all requesting, consumer always ready
    req_valid = 4'b1111;
    req_a = 16'h4321;
    req_b = 16'h3333;
    rsp_ready = 1'b1;
    for (int w = 0; w < 5; w++) begin
      #1;
      chk("ct_ready", 32'(req_ready), 32'h1 << order[w]);
      tick();
      tick();
      #1;
      chk("ct_valid", 32'(rsp_valid), 32'h1);
      chk("ct_id",    32'(rsp_id),    32'(order[w]));
      chk("ct_prod",  32'(rsp_prod),  32'((order[w] + 1) * 3));
      tick();
    end
    req_valid = 4'b0000;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
